// File: rtl/multicycle_controller.sv
// Multi-cycle RV32I control FSM: sequences FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK,
// traps on illegal opcodes or memory handshake timeout, and counts retired instructions.
module multicycle_controller #(
    parameter int unsigned MEM_TIMEOUT = 16,
    parameter int unsigned INSTRET_W   = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [31:0]          instr_in,
    input  logic                 mem_ready,
    input  logic                 alu_zero,
    output logic [6:0]           imm_opcode,
    output logic                 ir_write,
    output logic                 pc_write,
    output logic                 pc_src,
    output logic                 mem_req,
    output logic                 mem_we,
    output logic                 iord,
    output logic                 reg_write,
    output logic                 mem_to_reg,
    output logic [1:0]           alu_src_b,
    output logic [1:0]           alu_op,
    output logic                 trap,
    output logic [1:0]           trap_cause,
    output logic [INSTRET_W-1:0] instret,
    output logic [2:0]           state_dbg
);

    localparam int unsigned       WAIT_W    = 8;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

    localparam logic [2:0] S_IDLE      = 3'd0;
    localparam logic [2:0] S_FETCH     = 3'd1;
    localparam logic [2:0] S_DECODE    = 3'd2;
    localparam logic [2:0] S_EXECUTE   = 3'd3;
    localparam logic [2:0] S_MEMORY    = 3'd4;
    localparam logic [2:0] S_WRITEBACK = 3'd5;
    localparam logic [2:0] S_TRAP      = 3'd6;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_TIMEOUT = 2'b10;

    logic [2:0]           state_q,   state_d;
    logic [31:0]          ir_q,      ir_d;
    logic [WAIT_W-1:0]    wait_q,    wait_d;
    logic [INSTRET_W-1:0] instret_q, instret_d;
    logic                 trap_q,    trap_d;
    logic [1:0]           cause_q,   cause_d;

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       is_load, is_store, is_branch, is_rtype, is_itype;
    logic       is_legal, br_taken, timed_out;
    logic       unused_ir_bits;

    // Instruction fields decoded from the latched IR
    assign opcode    = ir_q[6:0];
    assign funct3    = ir_q[14:12];
    assign is_load   = (opcode == OP_LOAD);
    assign is_store  = (opcode == OP_STORE);
    assign is_branch = (opcode == OP_BRANCH);
    assign is_rtype  = (opcode == OP_RTYPE);
    assign is_itype  = (opcode == OP_ITYPE);
    assign is_legal  = is_load | is_store | is_rtype | is_itype
                     | (is_branch & (funct3[2:1] == 2'b00));
    assign br_taken  = ((funct3 == 3'b000) &  alu_zero)
                     | ((funct3 == 3'b001) & ~alu_zero);
    assign timed_out = (wait_q == WAIT_LAST) & ~mem_ready;

    // Remaining IR bits feed the datapath (register indices, immediates), not the controller
    assign unused_ir_bits = ^{ir_q[31:15], ir_q[11:7]};

    // State, IR, wait counter, retire counter and sticky trap registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= S_IDLE;
            ir_q      <= '0;
            wait_q    <= '0;
            instret_q <= '0;
            trap_q    <= 1'b0;
            cause_q   <= 2'b00;
        end else begin
            state_q   <= state_d;
            ir_q      <= ir_d;
            wait_q    <= wait_d;
            instret_q <= instret_d;
            trap_q    <= trap_d;
            cause_q   <= cause_d;
        end
    end

    // Next-state logic; wait counter is zero outside stalled memory accesses
    always_comb begin
        state_d   = state_q;
        ir_d      = ir_q;
        wait_d    = '0;
        instret_d = instret_q;
        trap_d    = trap_q;
        cause_d   = cause_q;
        case (state_q)
            S_IDLE: state_d = S_FETCH;
            S_FETCH: begin
                if (mem_ready) begin
                    ir_d    = instr_in;
                    state_d = S_DECODE;
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_DECODE: begin
                if (is_legal) begin
                    state_d = S_EXECUTE;
                end else begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_ILLEGAL;
                end
            end
            S_EXECUTE: begin
                if (is_load || is_store) begin
                    state_d = S_MEMORY;
                end else if (is_branch) begin
                    state_d   = S_FETCH;
                    instret_d = instret_q + INSTRET_W'(1);
                end else begin
                    state_d = S_WRITEBACK;
                end
            end
            S_MEMORY: begin
                if (mem_ready) begin
                    if (is_store) begin
                        state_d   = S_FETCH;
                        instret_d = instret_q + INSTRET_W'(1);
                    end else begin
                        state_d = S_WRITEBACK;
                    end
                end else if (timed_out) begin
                    state_d = S_TRAP;
                    cause_d = CAUSE_TIMEOUT;
                end else begin
                    wait_d = wait_q + WAIT_W'(1);
                end
            end
            S_WRITEBACK: begin
                state_d   = S_FETCH;
                instret_d = instret_q + INSTRET_W'(1);
            end
            S_TRAP:  state_d = S_TRAP;
            default: state_d = S_IDLE;
        endcase
        if (state_d == S_TRAP) trap_d = 1'b1;
    end

    // Datapath controls: Moore on state and IR, fetch enables qualified by mem_ready
    always_comb begin
        imm_opcode = 7'd0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        pc_src     = 1'b0;
        mem_req    = 1'b0;
        mem_we     = 1'b0;
        iord       = 1'b0;
        reg_write  = 1'b0;
        mem_to_reg = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        case (state_q)
            S_FETCH: begin
                mem_req  = 1'b1;
                ir_write = mem_ready;
                pc_write = mem_ready;
            end
            S_DECODE: imm_opcode = opcode;
            S_EXECUTE: begin
                imm_opcode = opcode;
                if (is_load || is_store) begin
                    alu_src_b = 2'b01;
                    alu_op    = 2'b00;
                end else if (is_branch) begin
                    alu_src_b = 2'b00;
                    alu_op    = 2'b01;
                    pc_write  = br_taken;
                    pc_src    = br_taken;
                end else if (is_rtype) begin
                    alu_src_b = 2'b00;
                    alu_op    = 2'b10;
                end else begin
                    alu_src_b = 2'b01;
                    alu_op    = 2'b10;
                end
            end
            S_MEMORY: begin
                imm_opcode = opcode;
                mem_req    = 1'b1;
                iord       = 1'b1;
                mem_we     = is_store;
            end
            S_WRITEBACK: begin
                imm_opcode = opcode;
                reg_write  = 1'b1;
                mem_to_reg = is_load;
            end
            default: ;
        endcase
    end

    assign trap       = trap_q;
    assign trap_cause = cause_q;
    assign instret    = instret_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: per-instruction expectations derived
// from opcode-level latency/enable rules, compared against observed per-instruction activity.
module tb_multicycle_controller;

    localparam int unsigned TO = 4;
    localparam int unsigned IW = 4;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;

    typedef struct packed {
        logic [7:0]    cycles;
        logic [7:0]    mreq;
        logic [7:0]    iord_n;
        logic [7:0]    we_n;
        logic [7:0]    rw_n;
        logic [7:0]    m2r_n;
        logic [7:0]    irw_n;
        logic [7:0]    pcw_n;
        logic [7:0]    taken_n;
        logic [6:0]    opc;
        logic [1:0]    srcb;
        logic [1:0]    aop;
        logic          trapped;
        logic [1:0]    cause;
        logic [IW-1:0] ret;
    } rec_t;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   instr_in;
    logic          mem_ready;
    logic          alu_zero;
    logic [6:0]    imm_opcode;
    logic          ir_write, pc_write, pc_src, mem_req, mem_we, iord;
    logic          reg_write, mem_to_reg, trap;
    logic [1:0]    alu_src_b, alu_op, trap_cause;
    logic [IW-1:0] instret;
    logic [2:0]    state_dbg;

    int            checks = 0;
    int            errors = 0;
    rec_t          sb[$];
    logic [IW-1:0] exp_ret = '0;

    multicycle_controller #(.MEM_TIMEOUT(TO), .INSTRET_W(IW)) dut (
        .clk(clk), .reset(reset), .instr_in(instr_in), .mem_ready(mem_ready),
        .alu_zero(alu_zero), .imm_opcode(imm_opcode), .ir_write(ir_write),
        .pc_write(pc_write), .pc_src(pc_src), .mem_req(mem_req), .mem_we(mem_we),
        .iord(iord), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .trap(trap), .trap_cause(trap_cause),
        .instret(instret), .state_dbg(state_dbg)
    );

    always #5 clk = ~clk;

    function automatic string rec_str(input rec_t r);
        return $sformatf("cyc=%0d req=%0d iord=%0d we=%0d rw=%0d m2r=%0d irw=%0d pcw=%0d tkn=%0d opc=%b srcb=%b aop=%b trap=%0d cause=%b ret=%0d",
                         r.cycles, r.mreq, r.iord_n, r.we_n, r.rw_n, r.m2r_n, r.irw_n,
                         r.pcw_n, r.taken_n, r.opc, r.srcb, r.aop, r.trapped, r.cause, r.ret);
    endfunction

    // Expected activity from FETCH entry until the next FETCH entry (or TRAP)
    function automatic rec_t model(input logic [31:0] ins, input int fd, input int md,
                                   input logic z, input logic [IW-1:0] ret_in);
        rec_t r;
        logic [6:0] op;
        logic [2:0] f3;
        int cyc, req, io, we, rw, m2r, pcw, tkn;
        bit retire, legal;
        r = '0;
        op = ins[6:0];
        f3 = ins[14:12];
        retire = 0;
        cyc = 0; req = 0; io = 0; we = 0; rw = 0; m2r = 0; pcw = 0; tkn = 0;
        legal = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) || (op == OP_ITYPE)
             || ((op == OP_BRANCH) && (f3 <= 3'd1));
        if (fd >= int'(TO)) begin
            cyc = TO; req = TO;
            r.trapped = 1'b1; r.cause = 2'b10;
        end else begin
            cyc = fd + 2; req = fd + 1; pcw = 1;
            r.irw_n = 8'd1;
            r.opc = op;
            if (!legal) begin
                r.trapped = 1'b1; r.cause = 2'b01;
            end else if (op == OP_LOAD || op == OP_STORE) begin
                r.srcb = 2'b01; r.aop = 2'b00;
                cyc += 1;
                if (md >= int'(TO)) begin
                    cyc += TO; req += TO; io = TO;
                    if (op == OP_STORE) we = TO;
                    r.trapped = 1'b1; r.cause = 2'b10;
                end else begin
                    cyc += md + 1; req += md + 1; io = md + 1;
                    if (op == OP_STORE) we = md + 1;
                    else begin cyc += 1; rw = 1; m2r = 1; end
                    retire = 1;
                end
            end else if (op == OP_BRANCH) begin
                r.srcb = 2'b00; r.aop = 2'b01;
                cyc += 1;
                if ((f3 == 3'd0 && z) || (f3 == 3'd1 && !z)) begin pcw += 1; tkn = 1; end
                retire = 1;
            end else begin
                r.srcb = (op == OP_RTYPE) ? 2'b00 : 2'b01;
                r.aop = 2'b10;
                cyc += 2; rw = 1;
                retire = 1;
            end
        end
        r.cycles = 8'(cyc); r.mreq = 8'(req); r.iord_n = 8'(io); r.we_n = 8'(we);
        r.rw_n = 8'(rw); r.m2r_n = 8'(m2r); r.pcw_n = 8'(pcw); r.taken_n = 8'(tkn);
        r.ret = retire ? IW'((int'(ret_in) + 1) % (1 << IW)) : ret_in;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h expected=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        #1;
        chk("reset_state", 32'(state_dbg), 32'd0);
        chk("reset_outputs", 32'({imm_opcode, ir_write, pc_write, pc_src, mem_req, mem_we, iord,
                                  reg_write, mem_to_reg, alu_src_b, alu_op, trap, trap_cause,
                                  instret}), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        exp_ret = '0;
        chk("idle_after_release", 32'(state_dbg), 32'd0);
        @(posedge clk);
        #1;
        chk("fetch_after_reset", 32'(state_dbg), 32'd1);
    endtask

    // Memory responder: answers each request after its planned number of wait cycles
    task automatic run_instr(input logic [31:0] ins, input int fd, input int md,
                             input logic z, output bit trapped);
        rec_t e;
        int fw, mw;
        bit accepted, done;
        e = model(ins, fd, md, z, exp_ret);
        sb.push_back(e);
        exp_ret = e.ret;
        trapped = e.trapped;
        instr_in = ins;
        alu_zero = z;
        fw = 0; mw = 0; accepted = 0; done = 0;
        for (int c = 0; c < 100 && !done; c++) begin
            if (trap) begin
                done = 1;
            end else if (mem_req && !iord) begin
                if (accepted) done = 1;
                else begin
                    mem_ready = (fw == fd);
                    if (fw == fd) accepted = 1;
                    fw++;
                end
            end else if (mem_req) begin
                mem_ready = (mw == md);
                mw++;
            end else begin
                mem_ready = 1'b0;
            end
            if (!done) begin
                @(posedge clk);
                #1;
            end
        end
        if (!done) begin
            checks++;
            errors++;
            $display("FAIL instr_budget ins=0x%08h did not complete, state=%0d", ins, state_dbg);
        end
    endtask

    task automatic trap_hold(input logic [1:0] cause);
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i % 2 == 0);
            @(posedge clk);
            #1;
        end
        chk("trap_sticky_state", 32'(state_dbg), 32'd6);
        chk("trap_flag", 32'(trap), 32'd1);
        chk("trap_cause_held", 32'(trap_cause), 32'(cause));
        chk("trap_instret", 32'(instret), 32'(exp_ret));
        chk("trap_enables", 32'({ir_write, pc_write, mem_req, mem_we, reg_write}), 32'd0);
        do_reset();
    endtask

    // Monitor: accumulates activity per instruction window and checks it against the scoreboard
    initial begin
        rec_t acc, e;
        bit open;
        logic [2:0] st, prev_st;
        open = 0;
        acc = '0;
        prev_st = 3'd0;
        forever begin
            @(negedge clk);
            if (reset) begin
                open = 0;
                prev_st = 3'd0;
            end else begin
                st = state_dbg;
                if ((st == 3'd1 && prev_st != 3'd1) || (st == 3'd6 && open)) begin
                    if (open) begin
                        acc.trapped = trap;
                        acc.cause = trap_cause;
                        acc.ret = instret;
                        checks++;
                        if (sb.size() == 0) begin
                            errors++;
                            $display("FAIL txn_unexpected got %s", rec_str(acc));
                        end else begin
                            e = sb.pop_front();
                            if (acc !== e) begin
                                errors++;
                                $display("FAIL txn got {%s} expected {%s}", rec_str(acc), rec_str(e));
                            end
                        end
                    end
                    open = (st == 3'd1);
                    acc = '0;
                end
                if (open) begin
                    acc.cycles  = acc.cycles + 8'd1;
                    acc.mreq    = acc.mreq + 8'(mem_req);
                    acc.iord_n  = acc.iord_n + 8'(mem_req & iord);
                    acc.we_n    = acc.we_n + 8'(mem_we);
                    acc.rw_n    = acc.rw_n + 8'(reg_write);
                    acc.m2r_n   = acc.m2r_n + 8'(reg_write & mem_to_reg);
                    acc.irw_n   = acc.irw_n + 8'(ir_write);
                    acc.pcw_n   = acc.pcw_n + 8'(pc_write);
                    acc.taken_n = acc.taken_n + 8'(pc_write & pc_src);
                    if (st == 3'd2) acc.opc = imm_opcode;
                    if (st == 3'd3) begin
                        acc.srcb = alu_src_b;
                        acc.aop = alu_op;
                    end
                end
                prev_st = st;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit tr;
        bit done;
        logic [31:0] ins;
        logic [6:0] op;
        int k, fd, md;
        reset = 1'b1;
        instr_in = '0;
        mem_ready = 1'b0;
        alu_zero = 1'b0;
        do_reset();

        run_instr(32'h002081B3, 0, 0, 1'b0, tr);
        run_instr(32'h0000A103, 0, 3, 1'b0, tr);
        run_instr(32'h00208463, 0, 0, 1'b1, tr);
        run_instr(32'h00208463, 0, 0, 1'b0, tr);
        run_instr(32'h00209463, 1, 0, 1'b1, tr);
        run_instr(32'h0020A023, 2, 1, 1'b0, tr);
        run_instr(32'h00A10113, 0, 0, 1'b0, tr);
        for (int i = 0; i < 14; i++) begin
            ins = $urandom;
            ins[6:0] = (i % 2 == 0) ? OP_RTYPE : OP_ITYPE;
            run_instr(ins, i % 3, 0, 1'b0, tr);
        end

        run_instr(32'h0000007F, 0, 0, 1'b0, tr);
        if (tr) trap_hold(2'b01);
        run_instr(32'h002081B3, int'(TO), 0, 1'b0, tr);
        if (tr) trap_hold(2'b10);
        run_instr(32'h002081B3, int'(TO) - 1, 0, 1'b0, tr);
        run_instr(32'h0000A103, 0, int'(TO), 1'b0, tr);
        if (tr) trap_hold(2'b10);

        for (int n = 0; n < 60; n++) begin
            k = int'($urandom_range(0, 9));
            ins = $urandom;
            case (k)
                0, 1:    op = OP_LOAD;
                2, 3:    op = OP_STORE;
                4:       op = OP_BRANCH;
                5, 6:    op = OP_RTYPE;
                7, 8:    op = OP_ITYPE;
                default: begin
                    op = 7'($urandom);
                    while (op inside {OP_LOAD, OP_STORE, OP_BRANCH, OP_RTYPE, OP_ITYPE})
                        op = 7'($urandom);
                end
            endcase
            ins[6:0] = op;
            fd = ($urandom_range(0, 15) == 0) ? int'(TO) : int'($urandom_range(0, TO - 1));
            md = ($urandom_range(0, 15) == 0) ? int'(TO) + 1 : int'($urandom_range(0, TO - 1));
            run_instr(ins, fd, md, 1'($urandom_range(0, 1)), tr);
            if (tr) trap_hold(trap_cause);
        end

        @(negedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb.size()), 32'd0);

        instr_in = 32'h0020A023;
        alu_zero = 1'b0;
        done = 0;
        for (int c = 0; c < 20 && !done; c++) begin
            if (state_dbg == 3'd4) done = 1;
            else begin
                mem_ready = mem_req & ~iord;
                @(posedge clk);
                #1;
            end
        end
        mem_ready = 1'b0;
        chk("store_reached_memory", 32'(done), 32'd1);
        #2;
        chk("store_we_before_reset", 32'({mem_we, mem_req}), 32'b11);
        reset = 1'b1;
        #1;
        chk("async_reset_we_req", 32'({mem_we, mem_req}), 32'd0);
        chk("async_reset_state", 32'(state_dbg), 32'd0);
        sb.delete();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        chk("fetch_after_async_reset", 32'(state_dbg), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
